// File: rtl/slave_irq_conditioner.sv
// Per-channel raw interrupt conditioner: 2-flop sync, debounce, minimum low time, clean release.
// Optional stuck-request detection is built when SLAVE_IRQ_STUCK_DETECT_EN is defined.
module slave_irq_conditioner #(
    parameter int N_CH            = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MIN_LOW_CYCLES  = 8,
    parameter int STUCK_CYCLES    = 1024
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] raw_irq,
    input  logic [N_CH-1:0] enable,
    output logic [N_CH-1:0] irq_n_out,
    output logic [N_CH-1:0] active,
    output logic [N_CH-1:0] stuck
);

    localparam int QW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(MIN_LOW_CYCLES + 1);
    localparam logic [QW-1:0] Q_ONE  = QW'(1);
    localparam logic [QW-1:0] Q_LAST = QW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_ONE  = HW'(1);
    localparam logic [HW-1:0] H_LOAD = HW'(MIN_LOW_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_QUAL     = 2'd1,
        ST_HOLD     = 2'd2,
        ST_WAIT_REL = 2'd3
    } state_t;

    if (DEBOUNCE_CYCLES < 1 || MIN_LOW_CYCLES < 1 || STUCK_CYCLES < 1) begin : g_bad_param
        $error("slave_irq_conditioner: DEBOUNCE_CYCLES, MIN_LOW_CYCLES and STUCK_CYCLES must be >= 1");
    end

    logic [N_CH-1:0] r_s1;
    logic [N_CH-1:0] r_s;

    // Two-flop synchroniser for the asynchronous requests
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= '0;
            r_s  <= '0;
        end else begin
            r_s1 <= raw_irq;
            r_s  <= r_s1;
        end
    end

`ifdef SLAVE_IRQ_STUCK_DETECT_EN
    localparam int SW = $clog2(STUCK_CYCLES + 1);
    localparam logic [SW-1:0] S_MAX  = SW'(STUCK_CYCLES);
    localparam logic [SW-1:0] S_LAST = SW'(STUCK_CYCLES - 1);
`endif

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        state_t          r_state;
        logic [QW-1:0]   r_dcnt;
        logic [HW-1:0]   r_hcnt;
        logic            r_irq_n;
        logic            r_active;

        // Channel FSM; r_dcnt debounces both the assert and the release
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_state  <= ST_IDLE;
                r_dcnt   <= '0;
                r_hcnt   <= '0;
                r_irq_n  <= 1'b1;
                r_active <= 1'b0;
            end else if (!enable[g]) begin
                r_state  <= ST_IDLE;
                r_dcnt   <= '0;
                r_hcnt   <= '0;
                r_irq_n  <= 1'b1;
                r_active <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_s[g] && (DEBOUNCE_CYCLES == 1)) begin
                            r_state  <= ST_HOLD;
                            r_dcnt   <= '0;
                            r_hcnt   <= H_LOAD;
                            r_irq_n  <= 1'b0;
                            r_active <= 1'b1;
                        end else if (r_s[g]) begin
                            r_state <= ST_QUAL;
                            r_dcnt  <= Q_ONE;
                        end else begin
                            r_dcnt <= '0;
                        end
                    end
                    ST_QUAL: begin
                        if (!r_s[g]) begin
                            r_state <= ST_IDLE;
                            r_dcnt  <= '0;
                        end else if (r_dcnt == Q_LAST) begin
                            r_state  <= ST_HOLD;
                            r_dcnt   <= '0;
                            r_hcnt   <= H_LOAD;
                            r_irq_n  <= 1'b0;
                            r_active <= 1'b1;
                        end else begin
                            r_dcnt <= r_dcnt + Q_ONE;
                        end
                    end
                    ST_HOLD: begin
                        if (r_hcnt == H_ONE) begin
                            r_state <= ST_WAIT_REL;
                            r_hcnt  <= '0;
                            r_dcnt  <= '0;
                        end else begin
                            r_hcnt <= r_hcnt - H_ONE;
                        end
                    end
                    ST_WAIT_REL: begin
                        if (r_s[g]) begin
                            r_dcnt <= '0;
                        end else if (r_dcnt == Q_LAST) begin
                            r_state  <= ST_IDLE;
                            r_dcnt   <= '0;
                            r_irq_n  <= 1'b1;
                            r_active <= 1'b0;
                        end else begin
                            r_dcnt <= r_dcnt + Q_ONE;
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_dcnt   <= '0;
                        r_hcnt   <= '0;
                        r_irq_n  <= 1'b1;
                        r_active <= 1'b0;
                    end
                endcase
            end
        end

        assign irq_n_out[g] = r_irq_n;
        assign active[g]    = r_active;

`ifdef SLAVE_IRQ_STUCK_DETECT_EN
        logic [SW-1:0] r_scnt;
        logic          r_stuck;
        logic          w_rel_done;

        assign w_rel_done = (r_state == ST_WAIT_REL) && !r_s[g] && (r_dcnt == Q_LAST);

        // Stuck counter: edges in WAIT_REL with the request still high
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_scnt  <= '0;
                r_stuck <= 1'b0;
            end else if (!enable[g] || (r_state != ST_WAIT_REL) || w_rel_done) begin
                r_scnt  <= '0;
                r_stuck <= 1'b0;
            end else if (r_s[g] && (r_scnt != S_MAX)) begin
                r_scnt <= r_scnt + SW'(1);
                if (r_scnt == S_LAST) begin
                    r_stuck <= 1'b1;
                end
            end
        end

        assign stuck[g] = r_stuck;
`else
        assign stuck[g] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_slave_irq_conditioner.sv
// Randomised and directed self-checking bench for slave_irq_conditioner against a behavioural model.
module tb_slave_irq_conditioner;

    localparam int N_CH = 8;
    localparam int DEB  = 4;
    localparam int MINL = 8;
    localparam int STK  = 1024;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N_CH-1:0] raw_irq;
    logic [N_CH-1:0] enable;
    logic [N_CH-1:0] irq_n_out;
    logic [N_CH-1:0] active;
    logic [N_CH-1:0] stuck;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: request pipeline plus "is low", run lengths and time since the falling edge
    bit m_s1 [N_CH];
    bit m_s  [N_CH];
    bit m_low[N_CH];
    int m_ones [N_CH];
    int m_age  [N_CH];
    int m_zeros[N_CH];
    int m_scnt [N_CH];
    bit m_stuck[N_CH];

    always #5 clk = ~clk;

    slave_irq_conditioner #(
        .N_CH(N_CH), .DEBOUNCE_CYCLES(DEB), .MIN_LOW_CYCLES(MINL), .STUCK_CYCLES(STK)
    ) dut (
        .clk(clk), .reset_n(reset_n), .raw_irq(raw_irq), .enable(enable),
        .irq_n_out(irq_n_out), .active(active), .stuck(stuck)
    );

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_s1[c] = 1'b0; m_s[c] = 1'b0; m_low[c] = 1'b0; m_ones[c] = 0;
            m_age[c] = 0; m_zeros[c] = 0; m_scnt[c] = 0; m_stuck[c] = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int c = 0; c < N_CH; c++) begin
            if (!enable[c]) begin
                m_low[c] = 1'b0; m_ones[c] = 0; m_age[c] = 0;
                m_zeros[c] = 0; m_scnt[c] = 0; m_stuck[c] = 1'b0;
            end else if (!m_low[c]) begin
                if (m_s[c]) begin
                    m_ones[c]++;
                    if (m_ones[c] >= DEB) begin
                        m_low[c] = 1'b1; m_ones[c] = 0; m_age[c] = 0; m_zeros[c] = 0;
                    end
                end else begin
                    m_ones[c] = 0;
                end
            end else if (m_age[c] < MINL) begin
                m_age[c]++;
            end else if (!m_s[c]) begin
                m_zeros[c]++;
                if (m_zeros[c] >= DEB) begin
                    m_low[c] = 1'b0; m_zeros[c] = 0; m_age[c] = 0;
                    m_scnt[c] = 0; m_stuck[c] = 1'b0;
                end
            end else begin
                m_zeros[c] = 0;
                if (m_scnt[c] < STK) m_scnt[c]++;
                if (m_scnt[c] >= STK) m_stuck[c] = 1'b1;
            end
            m_s[c]  = m_s1[c];
            m_s1[c] = raw_irq[c];
        end
        #1;
    endtask

    function automatic logic [N_CH-1:0] exp_irq_n();
        logic [N_CH-1:0] v;
        for (int c = 0; c < N_CH; c++) v[c] = ~m_low[c];
        return v;
    endfunction

    function automatic logic [N_CH-1:0] exp_active();
        logic [N_CH-1:0] v;
        for (int c = 0; c < N_CH; c++) v[c] = m_low[c];
        return v;
    endfunction

    function automatic logic [N_CH-1:0] exp_stuck();
        logic [N_CH-1:0] v;
        for (int c = 0; c < N_CH; c++) begin
`ifdef SLAVE_IRQ_STUCK_DETECT_EN
            v[c] = m_stuck[c];
`else
            v[c] = 1'b0;
`endif
        end
        return v;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; enable = 8'hFF; raw_irq = 8'h00;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({irq_n_out, active, stuck} !== {8'hFF, 8'h00, 8'h00}) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: got irq_n=%h act=%h stuck=%h want FF/00/00", k, irq_n_out, active, stuck);
            end
        end
        @(negedge clk); reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            n_checks++;
            if ({irq_n_out, active, stuck} !== {8'hFF, 8'h00, 8'h00}) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got irq_n=%h act=%h stuck=%h want FF/00/00", k, irq_n_out, active, stuck);
            end
        end
    endtask

    task automatic test_glitch();
        int lows = 0;
        raw_irq[0] = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (k == 2) raw_irq[0] = 1'b0;
            if (irq_n_out[0] == 1'b0) lows++;
            n_checks++;
            if ({irq_n_out, active, stuck} !== {exp_irq_n(), exp_active(), exp_stuck()}) begin
                n_fail++;
                $display("FAIL glitch cyc %0d: got %h/%h/%h want %h/%h/%h", k, irq_n_out, active, stuck,
                         exp_irq_n(), exp_active(), exp_stuck());
            end
        end
        n_checks++;
        if (lows !== 0) begin
            n_fail++;
            $display("FAIL glitch_no_fall: got %0d low cycles want 0", lows);
        end
    endtask

    task automatic test_single_pulse();
        int fall_edge = -1, rise_edge = -1, falls = 0;
        logic prev = 1'b1;
        raw_irq[3] = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (k == 5) raw_irq[3] = 1'b0;
            if (prev && !irq_n_out[3]) begin falls++; if (fall_edge < 0) fall_edge = k; end
            if (!prev && irq_n_out[3] && rise_edge < 0) rise_edge = k;
            prev = irq_n_out[3];
            n_checks++;
            if ({irq_n_out, active, stuck} !== {exp_irq_n(), exp_active(), exp_stuck()}) begin
                n_fail++;
                $display("FAIL pulse cyc %0d: got %h/%h/%h want %h/%h/%h", k, irq_n_out, active, stuck,
                         exp_irq_n(), exp_active(), exp_stuck());
            end
        end
        n_checks++;
        if (fall_edge !== 5) begin n_fail++; $display("FAIL pulse_fall_edge: got %0d want 5", fall_edge); end
        n_checks++;
        if (rise_edge !== 17) begin n_fail++; $display("FAIL pulse_rise_edge: got %0d want 17", rise_edge); end
        n_checks++;
        if (falls !== 1) begin n_fail++; $display("FAIL pulse_fall_count: got %0d want 1", falls); end
    endtask

    task automatic test_simultaneous();
        raw_irq[1] = 1'b1; raw_irq[6] = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (k == 9) begin raw_irq[1] = 1'b0; raw_irq[6] = 1'b0; end
            if (k == 4 || k == 5) begin
                n_checks++;
                if (irq_n_out !== ((k == 5) ? 8'hBD : 8'hFF)) begin
                    n_fail++;
                    $display("FAIL simul_edge%0d: got irq_n=%h want %h", k, irq_n_out, (k == 5) ? 8'hBD : 8'hFF);
                end
            end
            n_checks++;
            if ({irq_n_out, active, stuck} !== {exp_irq_n(), exp_active(), exp_stuck()}) begin
                n_fail++;
                $display("FAIL simul cyc %0d: got %h/%h/%h want %h/%h/%h", k, irq_n_out, active, stuck,
                         exp_irq_n(), exp_active(), exp_stuck());
            end
        end
    endtask

    task automatic test_enable();
        int falls = 0;
        logic prev = 1'b1;
        raw_irq[2] = 1'b1;
        for (int k = 0; k < 60; k++) begin
            step();
            if (k == 10) begin
                n_checks++;
                if (irq_n_out[2] !== 1'b0) begin n_fail++; $display("FAIL enable_low_before: got %b want 0", irq_n_out[2]); end
                enable[2] = 1'b0;
            end
            if (k == 11) begin
                n_checks++;
                if (irq_n_out[2] !== 1'b1) begin n_fail++; $display("FAIL enable_drop_rise: got %b want 1", irq_n_out[2]); end
            end
            if (k == 20) enable[2] = 1'b1;
            if (k == 40) raw_irq[2] = 1'b0;
            if (prev && !irq_n_out[2]) falls++;
            prev = irq_n_out[2];
            n_checks++;
            if ({irq_n_out, active, stuck} !== {exp_irq_n(), exp_active(), exp_stuck()}) begin
                n_fail++;
                $display("FAIL enable cyc %0d: got %h/%h/%h want %h/%h/%h", k, irq_n_out, active, stuck,
                         exp_irq_n(), exp_active(), exp_stuck());
            end
        end
        n_checks++;
        if (falls !== 2) begin n_fail++; $display("FAIL enable_fall_count: got %0d want 2", falls); end
    endtask

    task automatic test_stuck();
        int first_set = -1;
        raw_irq[7] = 1'b1;
        for (int k = 0; k < 2040; k++) begin
            step();
            if (k == 1999) raw_irq[7] = 1'b0;
            if (stuck[7] && first_set < 0) first_set = k;
            n_checks++;
            if ({irq_n_out, active, stuck} !== {exp_irq_n(), exp_active(), exp_stuck()}) begin
                n_fail++;
                $display("FAIL stuck cyc %0d: got %h/%h/%h want %h/%h/%h", k, irq_n_out, active, stuck,
                         exp_irq_n(), exp_active(), exp_stuck());
            end
        end
        n_checks++;
`ifdef SLAVE_IRQ_STUCK_DETECT_EN
        if (first_set !== 1037) begin n_fail++; $display("FAIL stuck_set_edge: got %0d want 1037", first_set); end
`else
        if (first_set !== -1) begin n_fail++; $display("FAIL stuck_never: got %0d want -1", first_set); end
`endif
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 9) == 0) raw_irq[c] = ~raw_irq[c];
                if (enable[c] ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 5) == 0)) enable[c] = ~enable[c];
            end
            step();
            n_checks++;
            if ({irq_n_out, active, stuck} !== {exp_irq_n(), exp_active(), exp_stuck()}) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h/%h/%h want %h/%h/%h", k, irq_n_out, active, stuck,
                         exp_irq_n(), exp_active(), exp_stuck());
            end
        end
        enable = 8'hFF; raw_irq = 8'h00;
        for (int k = 0; k < 40; k++) step();
    endtask

    task automatic test_reset_mid();
        raw_irq[5] = 1'b1;
        for (int k = 0; k < 8; k++) step();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({irq_n_out, active, stuck} !== {8'hFF, 8'h00, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %h/%h/%h want FF/00/00", irq_n_out, active, stuck);
        end
        raw_irq = 8'h00;
        @(posedge clk); @(negedge clk); reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            n_checks++;
            if ({irq_n_out, active, stuck} !== {8'hFF, 8'h00, 8'h00}) begin
                n_fail++;
                $display("FAIL reset_mid_after cyc %0d: got %h/%h/%h want FF/00/00", k, irq_n_out, active, stuck);
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_single_pulse();
        test_simultaneous();
        test_enable();
        test_stuck();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
